// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for rr_arbiter consumers
package rr_arb_pkg;

  localparam int CLIENTS     = 32;
  localparam int DATA_W      = 32;
  localparam int GRANT_CNT_W = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(CLIENTS);

  typedef logic [IDX_W-1:0] client_idx_t;

endpackage

// File: rtl/rr_grant_pipe_if.sv
// rtl/rr_grant_pipe_if.sv - valid/ready result interface of rr_grant_pipe
interface rr_grant_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_client;

  modport master (
    output out_valid,
    output out_data,
    output out_client,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_client,
    output out_ready
  );

endinterface

// File: rtl/rr_grant_pipe_onehot_to_idx.sv
// rtl/rr_grant_pipe_onehot_to_idx.sv - lowest-set-bit encoder with multi-hot flag
module onehot_to_idx
  import rr_arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             multi_hot
);

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(vec & (vec - N'(1)));

endmodule

// File: rtl/rr_grant_pipe.sv
// rr_grant_pipe.sv - captures arbiter winners into a 2-entry buffer and backpressures the arbiter
module rr_grant_pipe #(
  parameter int  CLIENTS = rr_arb_pkg::CLIENTS,
  parameter int  DATA_W  = rr_arb_pkg::DATA_W,
  localparam int IDX_W   = rr_arb_pkg::idx_width(CLIENTS)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [CLIENTS-1:0]                grant,
  input  logic [CLIENTS*DATA_W-1:0]         req_data,
  output logic                              stall,
  rr_grant_pipe_if.master                   out_if,
  output logic                              grant_err,
  output logic [rr_arb_pkg::GRANT_CNT_W-1:0] grant_cnt
);

  import rr_arb_pkg::*;

  typedef struct packed {
    logic [IDX_W-1:0]  client;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [IDX_W-1:0]       enc_idx;
  logic                   multi_hot;
  logic                   any_grant;
  logic                   push;
  logic                   pop;
  entry_t                 new_entry;
  entry_t                 head_q, head_d;
  entry_t                 tail_q, tail_d;
  logic [1:0]             count_q, count_d;
  logic                   err_q, err_d;
  logic [GRANT_CNT_W-1:0] cnt_q, cnt_d;

  onehot_to_idx #(
    .N     (CLIENTS),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec       (grant),
    .idx       (enc_idx),
    .multi_hot (multi_hot)
  );

  // Stall comes straight off the occupancy flops so the arbiter sees no comb path from grant/out_ready.
  assign stall = (count_q == 2'd2);

  always_comb begin
    any_grant        = |grant;
    push             = any_grant && !stall;
    pop              = (count_q != 2'd0) && out_if.out_ready;
    new_entry.client = enc_idx;
    new_entry.data   = req_data[enc_idx*DATA_W +: DATA_W];

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = new_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase

    // A grant while stalled breaks the arbiter contract just as a multi-hot grant does.
    err_d = err_q | (any_grant && (stall || multi_hot));
    cnt_d = (push && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_if.out_valid  = (count_q != 2'd0);
  assign out_if.out_data   = head_q.data;
  assign out_if.out_client = head_q.client;
  assign grant_err         = err_q;
  assign grant_cnt         = cnt_q;

endmodule

// File: tb/tb_rr_grant_pipe.sv
// tb/tb_rr_grant_pipe.sv - directed and random scoreboard bench for rr_grant_pipe
module tb_rr_grant_pipe;

  import rr_arb_pkg::*;

  typedef struct packed {
    client_idx_t       client;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [CLIENTS-1:0]        grant;
  logic [CLIENTS*DATA_W-1:0] req_data;
  logic                      stall;
  logic                      grant_err;
  logic [GRANT_CNT_W-1:0]    grant_cnt;

  rr_grant_pipe_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) out_if ();

  rr_grant_pipe #(
    .CLIENTS (CLIENTS),
    .DATA_W  (DATA_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .grant     (grant),
    .req_data  (req_data),
    .stall     (stall),
    .out_if    (out_if),
    .grant_err (grant_err),
    .grant_cnt (grant_cnt)
  );

  always #5 clock = ~clock;

  exp_t                   sb[$];
  logic                   exp_err = 1'b0;
  logic [GRANT_CNT_W-1:0] exp_cnt = '0;
  int                     compared = 0;
  int                     mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock with the current inputs, update the reference model, then check every output.
  task automatic cycle();
    logic m_stall;
    logic m_push;
    logic m_pop;
    logic was_reset;
    exp_t e;
    int   lo;
    m_stall   = (sb.size() == 2);
    m_push    = !reset && (grant != '0) && !m_stall;
    m_pop     = !reset && (sb.size() != 0) && out_if.out_ready;
    was_reset = reset;
    lo = 0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (grant[i]) lo = i;
    end
    e.client = client_idx_t'(lo);
    e.data   = req_data[lo*DATA_W +: DATA_W];
    @(posedge clock);
    #1;
    if (was_reset) begin
      sb.delete();
      exp_err = 1'b0;
      exp_cnt = '0;
    end else begin
      if ((grant != '0) && (m_stall || ($countones(grant) > 1))) exp_err = 1'b1;
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        sb.push_back(e);
        if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
    end
    chk("out_valid", 32'(out_if.out_valid), 32'(sb.size() != 0));
    chk("stall", 32'(stall), 32'(sb.size() == 2));
    chk("grant_err", 32'(grant_err), 32'(exp_err));
    chk("grant_cnt", 32'(grant_cnt), 32'(exp_cnt));
    if (sb.size() != 0) begin
      chk("out_client", 32'(out_if.out_client), 32'(sb[0].client));
      chk("out_data", out_if.out_data, sb[0].data);
    end else if (was_reset) begin
      chk("rst_out_client", 32'(out_if.out_client), 32'd0);
      chk("rst_out_data", out_if.out_data, 32'd0);
    end
  endtask

  task automatic drive(input logic [CLIENTS-1:0] g, input logic r);
    grant            = g;
    out_if.out_ready = r;
    cycle();
  endtask

  initial begin
    reset            = 1'b1;
    grant            = '0;
    out_if.out_ready = 1'b0;
    for (int i = 0; i < CLIENTS; i++) req_data[i*DATA_W +: DATA_W] = 32'hA5A5_0000 | 32'(i);

    drive('0, 1'b0);
    drive(32'd1 << 1, 1'b1);
    reset = 1'b0;

    // 1: single grant, one-cycle latency
    drive(32'd1 << 4, 1'b1);
    chk("t1_client", 32'(out_if.out_client), 32'd4);
    chk("t1_data", out_if.out_data, 32'hA5A5_0004);
    chk("t1_cnt", 32'(grant_cnt), 32'd1);
    drive('0, 1'b1);

    // 2: fill under backpressure, then drain in order
    drive(32'd1 << 3, 1'b0);
    drive(32'd1 << 7, 1'b0);
    chk("t2_stall_full", 32'(stall), 32'd1);
    drive('0, 1'b0);
    chk("t2_hold_client", 32'(out_if.out_client), 32'd3);
    drive('0, 1'b1);
    chk("t2_stall_drop", 32'(stall), 32'd0);
    chk("t2_second", 32'(out_if.out_client), 32'd7);
    drive('0, 1'b1);

    // 3: push and pop together at count 1
    drive(32'd1 << 2, 1'b0);
    drive(32'd1 << 9, 1'b1);
    chk("t3_valid", 32'(out_if.out_valid), 32'd1);
    chk("t3_client", 32'(out_if.out_client), 32'd9);
    drive('0, 1'b1);

    // 4: multi-hot grant is flagged sticky and encoded by lowest bit
    drive(32'h0000_0030, 1'b1);
    chk("t4_err", 32'(grant_err), 32'd1);
    chk("t4_client", 32'(out_if.out_client), 32'd4);
    drive('0, 1'b1);
    drive('0, 1'b1);
    chk("t4_sticky", 32'(grant_err), 32'd1);

    // random traffic with fresh payloads
    reset = 1'b1;
    drive('0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CLIENTS; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
      drive(($urandom_range(0, 3) == 0) ? '0 : (32'd1 << $urandom_range(0, CLIENTS - 1)),
            1'($urandom_range(0, 1)));
    end

    // 6: grant while stalled, then reset with a full buffer
    reset = 1'b1;
    drive('0, 1'b0);
    reset = 1'b0;
    drive(32'd1 << 1, 1'b0);
    drive(32'd1 << 2, 1'b0);
    chk("t6_full", 32'(stall), 32'd1);
    drive(32'd1 << 5, 1'b0);
    chk("t6_breach_err", 32'(grant_err), 32'd1);
    chk("t6_breach_head", 32'(out_if.out_client), 32'd1);
    reset = 1'b1;
    drive(32'd1 << 6, 1'b1);
    reset = 1'b0;
    chk("t6_valid", 32'(out_if.out_valid), 32'd0);
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_err", 32'(grant_err), 32'd0);
    chk("t6_cnt", 32'(grant_cnt), 32'd0);

    // 5: saturation of the grant counter
    for (int k = 0; k < 70000; k++) begin
      drive(32'd1 << (k % CLIENTS), 1'b1);
    end
    chk("t5_sat", 32'(grant_cnt), 32'h0000_FFFF);
    drive(32'd1 << 8, 1'b1);
    chk("t5_nowrap", 32'(grant_cnt), 32'h0000_FFFF);
    drive('0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
